// File: rtl/gardner_loop_ctrl.sv
// gardner_loop_ctrl: Gardner timing-loop filter with acquire/track gain scheduling and lock detection
// clk, rst      : single clock, synchronous active-high reset
// enable        : loop run enable; low returns the loop to IDLE
// sym_valid     : one-cycle strobe per recovered symbol
// ted_err       : raw Gardner timing error for the current symbol
// error_n       : filtered, negated, saturated error to the corrector
// GARDNER_SHIFT : corrector gain shift (ACQ_SHIFT while acquiring, TRK_SHIFT while tracking)
// locked        : timing lock flag
// state_dbg     : current FSM state encoding
module gardner_loop_ctrl #(
    parameter int WIDTH         = 16,
    parameter int WIN_LOG2      = 5,
    parameter int ACQ_SHIFT     = 2,
    parameter int TRK_SHIFT     = 5,
    parameter int KI_SHIFT      = 6,
    parameter int LOCK_THRESH   = 4096,
    parameter int UNLOCK_THRESH = 16384,
    parameter int LOCK_WINDOWS  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    sym_valid,
    input  logic signed [WIDTH-1:0] ted_err,
    output logic signed [WIDTH-1:0] error_n,
    output logic [3:0]              GARDNER_SHIFT,
    output logic                    locked,
    output logic [1:0]              state_dbg
);
    localparam int IW = WIDTH + 4;
    localparam int AW = WIDTH + WIN_LOG2;
    localparam int GW = $clog2(LOCK_WINDOWS + 1);
    localparam logic signed [WIDTH-1:0] E_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] E_MIN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic signed [IW-1:0] I_MAX = {1'b0, {(IW-1){1'b1}}};
    localparam logic signed [IW-1:0] I_MIN = {1'b1, {(IW-1){1'b0}}};
    localparam logic [AW-1:0] LOCK_T = AW'(LOCK_THRESH);
    localparam logic [AW-1:0] UNLOCK_T = AW'(UNLOCK_THRESH);
    typedef enum logic [1:0] {IDLE = 2'b00, ACQUIRE = 2'b01, TRACK = 2'b10, ILLEGAL = 2'b11} state_t;
    state_t                  state_q;
    logic signed [IW-1:0]    integ_q, integ_d, integ_sh;
    logic signed [IW:0]      integ_sum, filt, neg;
    logic signed [WIDTH-1:0] error_d;
    logic [WIDTH-1:0]        abs_err;
    logic [AW-1:0]           acc_q, total_d;
    logic [WIN_LOG2-1:0]     sym_cnt_q;
    logic [GW-1:0]           good_cnt_q;
    logic [1:0]              bad_cnt_q;
    logic                    win_end, good_win, bad_win;
    // One guard bit on every sum so overflow is visible before clamping.
    assign integ_sum = {integ_q[IW-1], integ_q} + {{5{ted_err[WIDTH-1]}}, ted_err};
    assign integ_d   = (integ_sum[IW] == integ_sum[IW-1]) ? integ_sum[IW-1:0] : (integ_sum[IW] ? I_MIN : I_MAX);
    assign integ_sh  = integ_q >>> KI_SHIFT;
    assign filt      = {integ_sh[IW-1], integ_sh} + {{5{ted_err[WIDTH-1]}}, ted_err};
    assign neg       = -filt;
    // Fits in WIDTH bits only when all bits above the WIDTH-bit sign agree with it.
    assign error_d   = (&neg[IW:WIDTH-1] || ~|neg[IW:WIDTH-1]) ? neg[WIDTH-1:0] : (neg[IW] ? E_MIN : E_MAX);
    // The most negative error has no positive twin; clamp its magnitude.
    assign abs_err   = ted_err[WIDTH-1] ? ((ted_err == E_MIN) ? E_MAX : -ted_err) : ted_err;
    assign total_d   = acc_q + {{WIN_LOG2{1'b0}}, abs_err};
    assign win_end   = &sym_cnt_q;
    assign good_win  = total_d < LOCK_T;
    assign bad_win   = total_d > UNLOCK_T;
    assign state_dbg = state_q;
    always_ff @(posedge clk) begin
        if (rst || !enable || state_q == ILLEGAL) begin
            state_q       <= IDLE;
            integ_q       <= '0;
            acc_q         <= '0;
            sym_cnt_q     <= '0;
            good_cnt_q    <= '0;
            bad_cnt_q     <= '0;
            error_n       <= '0;
            GARDNER_SHIFT <= 4'(ACQ_SHIFT);
            locked        <= 1'b0;
        end else if (state_q == IDLE) begin
            state_q <= ACQUIRE;
        end else if (sym_valid) begin
            integ_q   <= integ_d;
            error_n   <= error_d;
            acc_q     <= win_end ? '0 : total_d;
            sym_cnt_q <= sym_cnt_q + WIN_LOG2'(1);
            if (win_end && state_q == ACQUIRE) begin
                if (!good_win) begin
                    good_cnt_q <= '0;
                end else if (good_cnt_q + GW'(1) == GW'(LOCK_WINDOWS)) begin
                    state_q       <= TRACK;
                    locked        <= 1'b1;
                    GARDNER_SHIFT <= 4'(TRK_SHIFT);
                    good_cnt_q    <= '0;
                end else begin
                    good_cnt_q <= good_cnt_q + GW'(1);
                end
            end
            if (win_end && state_q == TRACK) begin
                if (!bad_win) begin
                    bad_cnt_q <= '0;
                end else if (bad_cnt_q == 2'd1) begin
                    state_q       <= ACQUIRE;
                    locked        <= 1'b0;
                    GARDNER_SHIFT <= 4'(ACQ_SHIFT);
                    bad_cnt_q     <= '0;
                    integ_q       <= '0;
                end else begin
                    bad_cnt_q <= bad_cnt_q + 2'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_gardner_loop_ctrl.sv
// tb_gardner_loop_ctrl: directed scoreboard bench for gardner_loop_ctrl at default parameters
module tb_gardner_loop_ctrl;
    typedef struct {int err; int lck; int shf; int st;} exp_t;
    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               enable = 1'b0;
    logic               sym_valid = 1'b0;
    logic signed [15:0] ted_err = '0;
    logic signed [15:0] error_n;
    logic [3:0]         gshift;
    logic               locked;
    logic [1:0]         state_dbg;
    int                 total = 0;
    int                 bad = 0;
    exp_t               q[$];
    exp_t               last;
    int                 m_integ, m_acc, m_cnt, m_good, m_bad, m_lck, m_shf, m_st;

    gardner_loop_ctrl dut (
        .clk(clk), .rst(rst), .enable(enable), .sym_valid(sym_valid), .ted_err(ted_err),
        .error_n(error_n), .GARDNER_SHIFT(gshift), .locked(locked), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic int clamp(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    task automatic m_reset();
        m_integ = 0; m_acc = 0; m_cnt = 0; m_good = 0; m_bad = 0;
        m_lck = 0; m_shf = 2; m_st = 0;
    endtask

    // Reference model of one accepted symbol; returns outputs expected after the edge.
    task automatic m_step(input int e, output exp_t x);
        int f, a, tot;
        f = e + (m_integ >>> 6);
        x.err = clamp(-f, -32768, 32767);
        m_integ = clamp(m_integ + e, -524288, 524287);
        a = (e == -32768) ? 32767 : ((e < 0) ? -e : e);
        m_acc += a;
        m_cnt++;
        if (m_cnt == 32) begin
            tot = m_acc; m_acc = 0; m_cnt = 0;
            if (m_st == 1) begin
                if (tot < 4096) begin
                    m_good++;
                    if (m_good == 4) begin m_st = 2; m_lck = 1; m_shf = 5; m_good = 0; end
                end else m_good = 0;
            end else if (m_st == 2) begin
                if (tot > 16384) begin
                    m_bad++;
                    if (m_bad == 2) begin m_st = 1; m_lck = 0; m_shf = 2; m_bad = 0; m_integ = 0; end
                end else m_bad = 0;
            end
        end
        x.lck = m_lck; x.shf = m_shf; x.st = m_st;
    endtask

    task automatic sym(input int e, input int gap);
        exp_t x, y;
        @(negedge clk);
        sym_valid = 1'b1;
        ted_err = 16'(e);
        m_step(e, x);
        q.push_back(x);
        @(negedge clk);
        sym_valid = 1'b0;
        y = q.pop_front();
        last = y;
        chk("sym_err", error_n, y.err);
        chk("sym_lock", locked, y.lck);
        chk("sym_shift", gshift, y.shf);
        chk("sym_state", state_dbg, y.st);
        repeat (gap) begin
            @(negedge clk);
            chk("hold_err", error_n, last.err);
            chk("hold_lock", locked, last.lck);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; enable = 1'b0; sym_valid = 1'b0; ted_err = '0;
        @(negedge clk);
        rst = 1'b0;
        m_reset();
    endtask

    task automatic go();
        @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
        m_st = 1;
        chk("go_state", state_dbg, 1);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_err", error_n, 0);
        chk("rst_shift", gshift, 2);
        chk("rst_lock", locked, 0);
        chk("rst_state", state_dbg, 0);
        rst = 1'b0;
        m_reset();
        go();
        sym(100, 30);
        chk("filt_1st", error_n, -100);
        sym(100, 30);
        chk("filt_2nd", error_n, -101);
        do_reset();
        go();
        repeat (127) sym(0, 0);
        chk("lock_early", locked, 0);
        sym(0, 0);
        chk("lock_set", locked, 1);
        chk("lock_shift", gshift, 5);
        chk("lock_state", state_dbg, 2);
        for (int i = 0; i < 63; i++) sym((i % 2 != 0) ? -2000 : 2000, 0);
        chk("unlock_early", locked, 1);
        sym(-2000, 0);
        chk("unlock_lock", locked, 0);
        chk("unlock_shift", gshift, 2);
        chk("unlock_integ", dut.integ_q, 0);
        chk("unlock_state", state_dbg, 1);
        do_reset();
        go();
        repeat (128) sym(0, 0);
        repeat (3) sym(500, 1);
        chk("pre_rst_state", state_dbg, 2);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_err", error_n, 0);
        chk("midrst_shift", gshift, 2);
        chk("midrst_lock", locked, 0);
        chk("midrst_state", state_dbg, 0);
        do_reset();
        go();
        repeat (20) sym(-32768, 0);
        chk("sat_err", error_n, 32767);
        chk("sat_integ", dut.integ_q, -524288);
        do_reset();
        go();
        repeat (9) sym(300, 1);
        @(negedge clk);
        sym_valid = 1'b1;
        ted_err = 16'sd5000;
        enable = 1'b0;
        @(negedge clk);
        sym_valid = 1'b0;
        chk("abort_state", state_dbg, 0);
        chk("abort_err", error_n, 0);
        chk("abort_lock", locked, 0);
        chk("abort_integ", dut.integ_q, 0);
        m_reset();
        go();
        sym(100, 0);
        chk("abort_resume", error_n, -100);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/gardner_loop_ctrl.md
GARDNER_LOOP_CTRL -- requirements
Module: gardner_loop_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 16, sample/error word width.
REQ-002 SHALL have parameter WIN_LOG2, default 5, lock-detect window = 2^WIN_LOG2 symbols.
REQ-003 SHALL have parameter ACQ_SHIFT, default 2, GARDNER_SHIFT in acquisition.
REQ-004 SHALL have parameter TRK_SHIFT, default 5, GARDNER_SHIFT in tracking.
REQ-005 SHALL have parameter KI_SHIFT, default 6, integrator right-shift in loop filter.
REQ-006 SHALL have parameter LOCK_THRESH, default 4096, window |error| sum below which a window counts as good.
REQ-007 SHALL have parameter UNLOCK_THRESH, default 16384, window |error| sum above which a window counts as bad.
REQ-008 SHALL have parameter LOCK_WINDOWS, default 4, consecutive good windows to declare lock.
REQ-009 SHALL have port clk, input, 1, 32.768M clock; the block uses one clock only.
REQ-010 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-011 SHALL have port enable, input, 1, loop run enable.
REQ-012 SHALL have port sym_valid, input, 1, one-cycle pulse per symbol, from corrector clk_out.
REQ-013 SHALL have port ted_err, input signed, WIDTH, raw Gardner timing error for the current symbol.
REQ-014 SHALL have port error_n, output reg signed, WIDTH, filtered negated error to the corrector.
REQ-015 SHALL have port GARDNER_SHIFT, output reg, 4, corrector gain shift.
REQ-016 SHALL have port locked, output reg, 1, timing lock flag.
REQ-017 SHALL have port state_dbg, output, 2, current FSM state encoding.

Function
REQ-018 SHALL implement FSM states IDLE=00, ACQUIRE=01, TRACK=10; encoding 11 SHALL return to IDLE next cycle.
REQ-019 SHALL move IDLE->ACQUIRE on the first cycle enable=1 is sampled; ANY state->IDLE on the cycle after enable=0 is sampled, overriding all other transitions.
REQ-020 SHALL, in IDLE, hold error_n=0, GARDNER_SHIFT=ACQ_SHIFT, locked=0, and keep integrator, window accumulator, symbol, good and bad counters at 0; sym_valid in IDLE is ignored.
REQ-021 SHALL, on sym_valid in ACQUIRE/TRACK, update integ (signed WIDTH+4) to integ+ted_err, saturated to [-2^(WIDTH+3), 2^(WIDTH+3)-1].
REQ-022 SHALL, on the same sym_valid, register error_n = sat_WIDTH(-(ted_err + (integ_old >>> KI_SHIFT))), where integ_old is the pre-update value; latency one cycle; range clamp [-2^(WIDTH-1), 2^(WIDTH-1)-1].
REQ-023 SHALL hold error_n constant between sym_valid pulses.
REQ-024 SHALL add |ted_err| to an unsigned WIDTH+WIN_LOG2 accumulator per sym_valid; |-2^(WIDTH-1)| SHALL be taken as 2^(WIDTH-1)-1.
REQ-025 SHALL count symbols modulo 2^WIN_LOG2; on the last symbol of a window, evaluate total = accumulator + current |ted_err|, then clear the accumulator and wrap the counter to 0.
REQ-026 SHALL, in ACQUIRE at window end, increment good_cnt if total < LOCK_THRESH, else clear it; when the increment reaches LOCK_WINDOWS, go to TRACK, set locked=1 and GARDNER_SHIFT=TRK_SHIFT, and clear good_cnt.
REQ-027 SHALL, in TRACK at window end, increment bad_cnt if total > UNLOCK_THRESH, else clear it; on reaching 2, go to ACQUIRE, set locked=0 and GARDNER_SHIFT=ACQ_SHIFT, and clear bad_cnt and integ.
REQ-028 SHALL change state, locked and GARDNER_SHIFT only at window boundaries, one cycle after the final sym_valid, except on enable/reset.
REQ-029 SHALL treat total equal to a threshold as neither good nor bad in the respective comparison.

Reset
REQ-030 SHALL, on rst=1 at a clk edge, set state=IDLE, error_n=0, GARDNER_SHIFT=ACQ_SHIFT, locked=0, and clear all counters, accumulators and integ; rst overrides enable and sym_valid.

Verification
REQ-031 SHALL test reset: rst pulse mid-TRACK -> next cycle error_n=0, GARDNER_SHIFT=2, locked=0, state_dbg=00.
REQ-032 SHALL test filter: enable=1, ted_err=100, sym_valid every 32 cycles -> error_n=-100 after the 1st symbol, -101 after the 2nd (integ 100>>>6=1).
REQ-033 SHALL test lock: ted_err=0 for 128 symbols -> locked=1 and GARDNER_SHIFT=5 one cycle after the 128th sym_valid, not earlier.
REQ-034 SHALL test unlock: locked, then ted_err alternating +/-2000 for 64 symbols -> locked=0, GARDNER_SHIFT=2 and integ=0 after the 64th symbol.
REQ-035 SHALL test saturation: ted_err=-32768 repeatedly -> error_n=32767 and integ clamps at -2^19 without wrap.
REQ-036 SHALL test abort: enable=0 on the 10th symbol of a window, coincident with sym_valid -> next cycle IDLE, error_n=0, and the pulse has no effect.
